// File: rtl/stage_memory1.sv
// stage_memory1: second memory pipeline stage -- dcache hit/miss resolution, refill/replay FSM,
// load alignment, store lane/mask generation and exception prioritisation.
package stage_memory1_pkg;
  typedef logic [3:0] ecause_t;
  localparam ecause_t CAUSE_LD_MISALIGN = 4'd4;
  localparam ecause_t CAUSE_ST_MISALIGN = 4'd6;
  localparam ecause_t CAUSE_LD_PAGEFAULT = 4'd13;
  localparam ecause_t CAUSE_ST_PAGEFAULT = 4'd15;
endpackage

module stage_memory1
  import stage_memory1_pkg::*;
(
  input  logic        clk_core,
  input  logic        reset_n,
  input  logic        mem0_valid,
  input  logic        mem0_exc,
  input  ecause_t     mem0_exc_cause,
  input  logic [31:2] mem0_pc,
  input  logic        mem0_read,
  input  logic        mem0_write,
  input  logic        mem0_extend,
  input  logic [1:0]  mem0_width,
  input  logic [31:0] mem0_addr,
  input  logic [31:0] mem0_wdata,
  input  logic [4:0]  mem0_wb_reg,
  output logic        mem1_stall,
  input  logic        dc_hit,
  input  logic        dc_fault,
  input  logic [31:0] dc_rdata,
  input  logic [28:2] dc_paddr,
  input  logic        dc_fill_done,
  output logic        mem1_dc_fill,
  output logic        mem1_dc_write,
  output logic [3:0]  mem1_dc_wmask,
  output logic [31:0] mem1_dc_wdata,
  output logic        mem1_mem0_read,
  output logic [28:2] mem1_mem0_addr,
  input  logic        wb_stall,
  output logic        mem1_valid,
  output logic        mem1_exc,
  output ecause_t     mem1_exc_cause,
  output logic [31:2] mem1_pc,
  output logic [4:0]  mem1_wb_reg,
  output logic [31:0] mem1_wb_data,
  output logic [31:0] mem1_fwd_data
);
  typedef enum logic [1:0] {IDLE, MISS, REPLAY, CHECK} state_t;
  state_t r_state, w_next;
  logic        r_valid, r_exc, r_read, r_write, r_extend;
  ecause_t     r_exc_cause;
  logic [31:2] r_pc;
  logic [1:0]  r_width;
  logic [31:0] r_addr, r_wdata;
  logic [4:0]  r_wb_reg;
  logic [28:2] r_paddr;
  logic        w_mem, w_lookup, w_misal, w_early, w_fault, w_exc, w_hit, w_complete, w_miss;
  ecause_t     w_cause;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld, w_wb_data;
  logic [3:0]  w_wmask;
  logic [31:0] w_wdata;

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      r_valid     <= 1'b0;
      r_exc       <= 1'b0;
      r_exc_cause <= '0;
      r_pc        <= '0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_extend    <= 1'b0;
      r_width     <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wb_reg    <= '0;
    end else if (!mem1_stall) begin
      r_valid     <= mem0_valid;
      r_exc       <= mem0_exc;
      r_exc_cause <= mem0_exc_cause;
      r_pc        <= mem0_pc;
      r_read      <= mem0_read;
      r_write     <= mem0_write;
      r_extend    <= mem0_extend;
      r_width     <= mem0_width;
      r_addr      <= mem0_addr;
      r_wdata     <= mem0_wdata;
      r_wb_reg    <= mem0_wb_reg;
    end
  end

  // Lookup results are only meaningful in IDLE (first lookup) and CHECK (replayed lookup).
  assign w_mem      = r_read | r_write;
  assign w_lookup   = (r_state == IDLE) || (r_state == CHECK);
  assign w_misal    = w_mem & ((r_width == 2'd1) ? r_addr[0] : (r_width[1] & (r_addr[1:0] != 2'd0)));
  assign w_early    = r_exc | w_misal;
  assign w_fault    = w_mem & ~w_early & dc_fault;
  assign w_exc      = w_early | w_fault;
  assign w_cause    = r_exc ? r_exc_cause :
                      w_misal ? (r_read ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN) :
                      (r_read ? CAUSE_LD_PAGEFAULT : CAUSE_ST_PAGEFAULT);
  assign w_hit      = w_mem & ~w_exc & dc_hit;
  assign w_complete = r_valid & w_lookup & (~w_mem | w_exc | dc_hit);
  assign w_miss     = r_valid & w_lookup & w_mem & ~w_exc & ~dc_hit;
  assign mem1_stall = r_valid & ~(w_complete & ~wb_stall);

  // A completed lookup held by wb_stall in CHECK must stay in CHECK so the replayed hit is reused.
  always_comb begin
    w_next = w_miss ? MISS :
             (r_state == MISS) ? (dc_fill_done ? REPLAY : MISS) :
             (r_state == REPLAY) ? CHECK :
             ((r_state == CHECK) && wb_stall) ? CHECK : IDLE;
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_paddr <= '0;
    end else begin
      r_state <= w_next;
      if (w_miss) r_paddr <= dc_paddr;
    end
  end

  assign mem1_dc_fill   = (r_state == MISS);
  assign mem1_mem0_read = (r_state == REPLAY);
  assign mem1_mem0_addr = mem1_mem0_read ? r_paddr : '0;

  assign w_byte    = dc_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_half    = r_addr[1] ? dc_rdata[31:16] : dc_rdata[15:0];
  assign w_ld      = (r_width == 2'd0) ? {{24{r_extend & w_byte[7]}}, w_byte} :
                     (r_width == 2'd1) ? {{16{r_extend & w_half[15]}}, w_half} : dc_rdata;
  assign w_wb_data = r_read ? w_ld : r_addr;
  assign mem1_fwd_data = w_wb_data;

  assign w_wmask = (r_width == 2'd0) ? (4'b0001 << r_addr[1:0]) :
                   (r_width == 2'd1) ? (4'b0011 << {r_addr[1], 1'b0}) : 4'b1111;
  assign w_wdata = (r_width == 2'd0) ? {4{r_wdata[7:0]}} :
                   (r_width == 2'd1) ? {2{r_wdata[15:0]}} : r_wdata;
  // Write only on the cycle the store actually leaves, so a wb_stall hold never writes twice.
  assign mem1_dc_write = r_write & w_hit & w_complete & ~wb_stall;
  assign mem1_dc_wmask = mem1_dc_write ? w_wmask : 4'b0000;
  assign mem1_dc_wdata = mem1_dc_write ? w_wdata : '0;

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      mem1_valid     <= 1'b0;
      mem1_exc       <= 1'b0;
      mem1_exc_cause <= '0;
      mem1_pc        <= '0;
      mem1_wb_reg    <= '0;
      mem1_wb_data   <= '0;
    end else if (!wb_stall) begin
      mem1_valid     <= r_valid & w_complete;
      mem1_exc       <= w_exc;
      mem1_exc_cause <= w_exc ? w_cause : '0;
      mem1_pc        <= r_pc;
      mem1_wb_reg    <= w_exc ? 5'd0 : r_wb_reg;
      mem1_wb_data   <= w_wb_data;
    end
  end
endmodule

// File: tb/tb_stage_memory1.sv
// tb_stage_memory1: directed scoreboard bench for stage_memory1; retirements and dcache
// writes are checked by a negedge monitor against queues filled when stimulus is issued.
module tb_stage_memory1;
  import stage_memory1_pkg::*;
  logic clk_core, reset_n;
  logic mem0_valid, mem0_exc, mem0_read, mem0_write, mem0_extend;
  ecause_t mem0_exc_cause;
  logic [31:2] mem0_pc;
  logic [1:0] mem0_width;
  logic [31:0] mem0_addr, mem0_wdata;
  logic [4:0] mem0_wb_reg;
  logic mem1_stall, dc_hit, dc_fault, dc_fill_done;
  logic [31:0] dc_rdata;
  logic [28:2] dc_paddr;
  logic mem1_dc_fill, mem1_dc_write, mem1_mem0_read, wb_stall;
  logic [3:0] mem1_dc_wmask;
  logic [31:0] mem1_dc_wdata;
  logic [28:2] mem1_mem0_addr;
  logic mem1_valid, mem1_exc;
  ecause_t mem1_exc_cause;
  logic [31:2] mem1_pc;
  logic [4:0] mem1_wb_reg;
  logic [31:0] mem1_wb_data, mem1_fwd_data;

  typedef struct {
    logic exc; ecause_t cause; logic [4:0] rg; logic [31:0] data; logic chk_data; logic [31:2] pc;
  } exp_t;
  typedef struct { logic [3:0] mask; logic [31:0] data; } wr_t;
  exp_t q[$];
  wr_t wq[$];
  exp_t e;
  wr_t w;
  int checks = 0, errors = 0;
  logic [31:2] pc_n = 30'h100;

  stage_memory1 dut (
    .clk_core(clk_core), .reset_n(reset_n), .mem0_valid(mem0_valid), .mem0_exc(mem0_exc),
    .mem0_exc_cause(mem0_exc_cause), .mem0_pc(mem0_pc), .mem0_read(mem0_read),
    .mem0_write(mem0_write), .mem0_extend(mem0_extend), .mem0_width(mem0_width),
    .mem0_addr(mem0_addr), .mem0_wdata(mem0_wdata), .mem0_wb_reg(mem0_wb_reg),
    .mem1_stall(mem1_stall), .dc_hit(dc_hit), .dc_fault(dc_fault), .dc_rdata(dc_rdata),
    .dc_paddr(dc_paddr), .dc_fill_done(dc_fill_done), .mem1_dc_fill(mem1_dc_fill),
    .mem1_dc_write(mem1_dc_write), .mem1_dc_wmask(mem1_dc_wmask), .mem1_dc_wdata(mem1_dc_wdata),
    .mem1_mem0_read(mem1_mem0_read), .mem1_mem0_addr(mem1_mem0_addr), .wb_stall(wb_stall),
    .mem1_valid(mem1_valid), .mem1_exc(mem1_exc), .mem1_exc_cause(mem1_exc_cause),
    .mem1_pc(mem1_pc), .mem1_wb_reg(mem1_wb_reg), .mem1_wb_data(mem1_wb_data),
    .mem1_fwd_data(mem1_fwd_data)
  );

  initial clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_core);
    #1;
  endtask

  task automatic mem0_set(input logic rd, input logic wr, input logic ext, input logic [1:0] wd_w,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rg,
                          input logic ex, input ecause_t c);
    mem0_valid = 1'b1; mem0_read = rd; mem0_write = wr; mem0_extend = ext; mem0_width = wd_w;
    mem0_addr = a; mem0_wdata = wd; mem0_wb_reg = rg; mem0_exc = ex; mem0_exc_cause = c;
    mem0_pc = pc_n;
    pc_n = pc_n + 30'd1;
  endtask

  task automatic push(input logic ex, input ecause_t c, input logic [4:0] rg, input logic [31:0] d,
                      input logic cd);
    exp_t x;
    x.exc = ex; x.cause = c; x.rg = rg; x.data = d; x.chk_data = cd; x.pc = mem0_pc;
    q.push_back(x);
  endtask

  task automatic push_wr(input logic [3:0] m, input logic [31:0] d);
    wr_t x;
    x.mask = m; x.data = d;
    wq.push_back(x);
  endtask

  // Instruction was just presented on mem0; hold it one cycle with the given lookup result.
  task automatic run1(input logic h, input logic f, input logic [31:0] rd);
    tick;
    mem0_valid = 1'b0; dc_hit = h; dc_fault = f; dc_rdata = rd;
    #1;
    chk("stall_single_cycle", {31'd0, mem1_stall}, 32'd0);
    tick;
    dc_hit = 1'b0; dc_fault = 1'b0;
  endtask

  always @(negedge clk_core) begin
    if (reset_n && mem1_valid && !wb_stall) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_retire got_pc=%h want=none", mem1_pc);
      end else begin
        e = q.pop_front();
        chk("retire_exc", {31'd0, mem1_exc}, {31'd0, e.exc});
        chk("retire_cause", {28'd0, mem1_exc_cause}, {28'd0, e.cause});
        chk("retire_wb_reg", {27'd0, mem1_wb_reg}, {27'd0, e.rg});
        chk("retire_pc", {2'd0, mem1_pc}, {2'd0, e.pc});
        if (e.chk_data) chk("retire_wb_data", mem1_wb_data, e.data);
      end
    end
    if (reset_n && mem1_dc_write) begin
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_dc_write got_mask=%b want=none", mem1_dc_wmask);
      end else begin
        w = wq.pop_front();
        chk("dc_wmask", {28'd0, mem1_dc_wmask}, {28'd0, w.mask});
        chk("dc_wdata", mem1_dc_wdata, w.data);
      end
    end
  end

  initial begin
    reset_n = 1'b0; wb_stall = 1'b0;
    mem0_valid = 0; mem0_exc = 0; mem0_exc_cause = '0; mem0_pc = '0; mem0_read = 0; mem0_write = 0;
    mem0_extend = 0; mem0_width = 0; mem0_addr = 0; mem0_wdata = 0; mem0_wb_reg = 0;
    dc_hit = 0; dc_fault = 0; dc_rdata = 0; dc_paddr = '0; dc_fill_done = 0;
    repeat (2) tick;
    chk("rst_valid", {31'd0, mem1_valid}, 32'd0);
    chk("rst_stall", {31'd0, mem1_stall}, 32'd0);
    chk("rst_fill", {31'd0, mem1_dc_fill}, 32'd0);
    chk("rst_wb_data", mem1_wb_data, 32'd0);
    reset_n = 1'b1;
    tick;
    // lbu then lb back-to-back on the same hit word
    mem0_set(1, 0, 0, 2'd0, 32'h1003, 0, 5'd5, 0, '0);
    push(0, '0, 5'd5, 32'h00000080, 1);
    tick;
    dc_hit = 1; dc_rdata = 32'h80FF_1234;
    mem0_set(1, 0, 1, 2'd0, 32'h1003, 0, 5'd6, 0, '0);
    push(0, '0, 5'd6, 32'hFFFFFF80, 1);
    #1;
    chk("stall_lbu", {31'd0, mem1_stall}, 32'd0);
    tick;
    mem0_valid = 0;
    #1;
    chk("stall_lb", {31'd0, mem1_stall}, 32'd0);
    tick;
    dc_hit = 0;
    // lh / lhu upper half
    mem0_set(1, 0, 1, 2'd1, 32'h6002, 0, 5'd11, 0, '0);
    push(0, '0, 5'd11, 32'hFFFF8001, 1);
    run1(1, 0, 32'h8001_0000);
    mem0_set(1, 0, 0, 2'd1, 32'h6002, 0, 5'd12, 0, '0);
    push(0, '0, 5'd12, 32'h00008001, 1);
    run1(1, 0, 32'h8001_0000);
    // sh and sb hit stores
    mem0_set(0, 1, 0, 2'd1, 32'h2002, 32'h0000ABCD, 5'd0, 0, '0);
    push(0, '0, 5'd0, 32'h00002002, 1);
    push_wr(4'b1100, 32'hABCDABCD);
    run1(1, 0, 32'h0);
    mem0_set(0, 1, 0, 2'd0, 32'h7001, 32'h0000005A, 5'd0, 0, '0);
    push(0, '0, 5'd0, 32'h00007001, 1);
    push_wr(4'b0010, 32'h5A5A5A5A);
    run1(1, 0, 32'h0);
    // non-memory op passes the ALU result, ignoring the lookup
    mem0_set(0, 0, 0, 2'd2, 32'h12345678, 0, 5'd9, 0, '0);
    push(0, '0, 5'd9, 32'h12345678, 1);
    run1(0, 0, 32'h0);
    // misaligned word load, faulting store, passed-through earlier exception
    mem0_set(1, 0, 0, 2'd2, 32'h3002, 0, 5'd8, 0, '0);
    push(1, 4'd4, 5'd0, 0, 0);
    run1(0, 0, 32'h0);
    chk("misalign_no_fill", {31'd0, mem1_dc_fill}, 32'd0);
    mem0_set(0, 1, 0, 2'd2, 32'h5000, 32'h55, 5'd4, 0, '0);
    push(1, 4'd15, 5'd0, 0, 0);
    run1(0, 1, 32'h0);
    mem0_set(0, 1, 0, 2'd1, 32'h5001, 32'h55, 5'd4, 0, '0);
    push(1, 4'd6, 5'd0, 0, 0);
    run1(1, 1, 32'h0);
    mem0_set(1, 0, 0, 2'd2, 32'h3001, 0, 5'd10, 1, 4'd2);
    push(1, 4'd2, 5'd0, 0, 0);
    run1(0, 1, 32'h0);
    // lw miss -> refill -> replay -> check hit
    mem0_set(1, 0, 0, 2'd2, 32'h4008, 0, 5'd7, 0, '0);
    push(0, '0, 5'd7, 32'hDEADBEEF, 1);
    tick;
    mem0_valid = 0; dc_hit = 0; dc_paddr = 27'h0123456;
    #1;
    chk("miss_stall_idle", {31'd0, mem1_stall}, 32'd1);
    tick;
    dc_paddr = 27'h0;
    for (int i = 0; i < 5; i++) begin
      chk("miss_stall", {31'd0, mem1_stall}, 32'd1);
      chk("miss_fill", {31'd0, mem1_dc_fill}, 32'd1);
      chk("miss_no_replay", {31'd0, mem1_mem0_read}, 32'd0);
      tick;
    end
    dc_fill_done = 1;
    chk("fill_held", {31'd0, mem1_dc_fill}, 32'd1);
    tick;
    dc_fill_done = 0;
    chk("replay_read", {31'd0, mem1_mem0_read}, 32'd1);
    chk("replay_addr", {5'd0, mem1_mem0_addr}, 32'h0123456);
    chk("replay_stall", {31'd0, mem1_stall}, 32'd1);
    chk("replay_no_fill", {31'd0, mem1_dc_fill}, 32'd0);
    tick;
    dc_hit = 1; dc_rdata = 32'hDEADBEEF;
    #1;
    chk("check_no_replay", {31'd0, mem1_mem0_read}, 32'd0);
    chk("check_stall_drop", {31'd0, mem1_stall}, 32'd0);
    tick;
    dc_hit = 0;
    chk("after_check_valid", {31'd0, mem1_valid}, 32'd1);
    tick;
    // hit store held by wb_stall writes only on the release cycle
    mem0_set(0, 1, 0, 2'd2, 32'h8004, 32'h11223344, 5'd0, 0, '0);
    push(0, '0, 5'd0, 32'h00008004, 1);
    push_wr(4'b1111, 32'h11223344);
    tick;
    mem0_valid = 0; dc_hit = 1; wb_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wbstall_no_write", {31'd0, mem1_dc_write}, 32'd0);
      chk("wbstall_stall", {31'd0, mem1_stall}, 32'd1);
      tick;
    end
    wb_stall = 0;
    #1;
    chk("release_write", {31'd0, mem1_dc_write}, 32'd1);
    tick;
    dc_hit = 0;
    tick;
    // reset during MISS abandons the refill immediately
    mem0_set(1, 0, 0, 2'd2, 32'h9000, 0, 5'd3, 0, '0);
    tick;
    mem0_valid = 0; dc_hit = 0;
    tick;
    chk("pre_reset_fill", {31'd0, mem1_dc_fill}, 32'd1);
    reset_n = 0;
    #1;
    chk("arst_fill", {31'd0, mem1_dc_fill}, 32'd0);
    chk("arst_stall", {31'd0, mem1_stall}, 32'd0);
    chk("arst_valid", {31'd0, mem1_valid}, 32'd0);
    chk("arst_write", {31'd0, mem1_dc_write}, 32'd0);
    chk("arst_replay", {31'd0, mem1_mem0_read}, 32'd0);
    chk("arst_wb_data", mem1_wb_data, 32'd0);
    tick;
    reset_n = 1;
    repeat (2) tick;
    chk("post_reset_fill", {31'd0, mem1_dc_fill}, 32'd0);
    chk("scoreboard_empty", q.size(), 32'd0);
    chk("write_queue_empty", wq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stage_memory1.md
STAGE_MEMORY1 -- requirements
Module: stage_memory1

Interface
REQ-001 Parameters: none.
REQ-002 clk_core  in  1  core clock; all state updates on its rising edge.
REQ-003 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-004 mem0_valid, mem0_exc  in  1 each  memory0 stage occupied / carries an exception.
REQ-005 mem0_exc_cause  in  ecause_t; mem0_pc  in  [31:2]  exception cause and instruction PC.
REQ-006 mem0_read, mem0_write, mem0_extend  in  1 each  load, store, sign-extend load.
REQ-007 mem0_width  in  2  access width: 0 byte, 1 half, 2 word.
REQ-008 mem0_addr, mem0_wdata  in  32 each  effective address (ALU result for non-memory ops) and store data.
REQ-009 mem0_wb_reg  in  5  destination register.
REQ-010 mem1_stall  out  1  hold memory0.
REQ-011 dc_hit, dc_fault  in  1 each  dcache lookup result for the access held in this stage, valid the cycle after mem0 issued it.
REQ-012 dc_rdata  in  32  hit word; dc_paddr  in  [28:2]  translated word address.
REQ-013 dc_fill_done  in  1  one-cycle pulse: miss refill complete.
REQ-014 mem1_dc_fill  out  1  refill request, held until dc_fill_done.
REQ-015 mem1_dc_write  out  1; mem1_dc_wmask  out  4; mem1_dc_wdata  out  32  store port, single-cycle write of the hit line.
REQ-016 mem1_mem0_read  out  1; mem1_mem0_addr  out  [28:2]  replay lookup through memory0's dcache port.
REQ-017 wb_stall  in  1  writeback cannot accept.
REQ-018 mem1_valid, mem1_exc  out  1 each; mem1_exc_cause  out  ecause_t; mem1_pc  out  [31:2]  to writeback.
REQ-019 mem1_wb_reg  out  5; mem1_wb_data  out  32  writeback destination and value.
REQ-020 mem1_fwd_data  out  32  combinational wb value of held instruction, for decode forwarding.

Function
REQ-021 Stage register (r_*) loads all mem0_* fields when mem1_stall=0; r_valid <= mem0_valid.
REQ-022 FSM states IDLE, MISS, REPLAY, CHECK; IDLE->MISS on held load/store with dc_hit=0, dc_fault=0, no earlier exception; r_paddr <= dc_paddr.
REQ-023 MISS: mem1_dc_fill=1; ->REPLAY on dc_fill_done.
REQ-024 REPLAY: mem1_mem0_read=1, mem1_mem0_addr=r_paddr, exactly one cycle; ->CHECK.
REQ-025 CHECK: dc_hit=1 -> complete, ->IDLE; dc_hit=0 -> MISS again.
REQ-026 Priority: r_exc (pass cause through) > misaligned > dc_fault > hit/miss; misaligned = half with addr[0]=1, or word with addr[1:0]!=0.
REQ-027 Causes: load misaligned 4, store misaligned 6, load page fault 13, store page fault 15; exceptions suppress dcache write and force mem1_wb_reg=0.
REQ-028 Load data: byte lane addr[1:0], half lane addr[1]; zero-extend, sign-extend when r_extend=1; word passes unchanged.
REQ-029 Store on completing hit: mem1_dc_write=1 one cycle; wmask 0001<<addr[1:0] (byte), 0011<<{addr[1],0} (half), 1111 (word); wdata = lane-replicated r_wdata.
REQ-030 Non-memory op: completes immediately, wb_data=r_addr.
REQ-031 mem1_stall = r_valid & ~(complete & ~wb_stall); dcache write asserted only when ~wb_stall, so each store writes exactly once.
REQ-032 Output registers update when wb_stall=0: mem1_valid <= r_valid & complete; others from held instruction.
REQ-033 FSM never leaves IDLE when r_valid=0; dc_* ignored then.

Reset
REQ-034 reset_n=0 asynchronously: r_valid=0, mem1_valid=0, FSM=IDLE, mem1_dc_fill=0, mem1_dc_write=0, mem1_mem0_read=0, mem1_stall=0; mid-miss reset abandons refill; remaining outputs 0.

Verification
REQ-035 lbu addr 0x1003, dc_rdata 0x80FF_1234, hit -> mem1_wb_data 0x00000080 next cycle; lb -> 0xFFFFFF80; no stall.
REQ-036 sh addr 0x2002, wdata 0x0000ABCD, hit -> mem1_dc_write one cycle, wmask 1100, wdata 0xABCDABCD.
REQ-037 lw miss, dc_paddr 0x0123456, dc_fill_done after 5 cycles -> stall held throughout, one-cycle mem1_mem0_read addr 0x0123456, hit in CHECK -> mem1_valid, stall drops.
REQ-038 lw addr 0x3002 -> mem1_exc=1 cause 4, no fill, wb_reg 0; sw with dc_fault=1 -> cause 15.
REQ-039 Hit store with wb_stall=1 for 3 cycles -> write only on release cycle; reset_n low during MISS -> all REQ-034 values immediately.
